// File: rtl/stopwatch_bcd_core.sv
// MM:SS stopwatch core: button edge detection, run/pause/idle control,
// 1 Hz prescaler, four-digit BCD cascade and lap snapshot. The digit
// outputs are registered copies of either the live count or the lap
// snapshot.
module stopwatch_bcd_core #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] first,
  output logic [3:0] second,
  output logic [3:0] third,
  output logic [3:0] fourth,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  state_t           state, state_nx;
  logic             ss_prev, clr_prev, lap_prev;
  logic [CNT_W-1:0] presc, presc_nx;
  logic [3:0]       sec_ones, sec_tens, min_ones, min_tens;
  logic [3:0]       sec_ones_nx, sec_tens_nx, min_ones_nx, min_tens_nx;
  logic [3:0]       snap_so, snap_st, snap_mo, snap_mt;
  logic [3:0]       snap_so_nx, snap_st_nx, snap_mo_nx, snap_mt_nx;
  logic             lap_nx;
  logic             press_clr, press_ss, press_lap;
  logic             count_en, tick, wrap;

  // Press decode with clear > start_stop > lap priority; the prescaler
  // stands still in the cycle that a start_stop press takes us out of RUN.
  always_comb begin
    press_clr = clear & ~clr_prev;
    press_ss  = start_stop & ~ss_prev & ~press_clr;
    press_lap = lap & ~lap_prev & ~press_clr & ~press_ss;
    count_en  = (state == RUN) & ~press_ss & ~press_clr;
    tick      = count_en & (presc == LAST);
  end

  // Next-state, prescaler, BCD cascade and lap snapshot.
  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    sec_ones_nx = sec_ones;
    sec_tens_nx = sec_tens;
    min_ones_nx = min_ones;
    min_tens_nx = min_tens;
    snap_so_nx  = snap_so;
    snap_st_nx  = snap_st;
    snap_mo_nx  = snap_mo;
    snap_mt_nx  = snap_mt;
    lap_nx      = lap_active;
    wrap        = 1'b0;
    if (press_clr) begin
      state_nx    = IDLE;
      presc_nx    = '0;
      sec_ones_nx = 4'd0;
      sec_tens_nx = 4'd0;
      min_ones_nx = 4'd0;
      min_tens_nx = 4'd0;
      lap_nx      = 1'b0;
    end else begin
      if (press_ss) begin
        case (state)
          IDLE:    state_nx = RUN;
          RUN:     state_nx = PAUSE;
          PAUSE:   state_nx = RUN;
          default: state_nx = IDLE;
        endcase
      end
      if (count_en) begin
        if (tick) begin
          presc_nx = '0;
          if (sec_ones == 4'd9) begin
            sec_ones_nx = 4'd0;
            if (sec_tens == 4'd5) begin
              sec_tens_nx = 4'd0;
              if (min_ones == 4'd9) begin
                min_ones_nx = 4'd0;
                if (min_tens == 4'd5) begin
                  min_tens_nx = 4'd0;
                  wrap        = 1'b1;
                end else begin
                  min_tens_nx = min_tens + 4'd1;
                end
              end else begin
                min_ones_nx = min_ones + 4'd1;
              end
            end else begin
              sec_tens_nx = sec_tens + 4'd1;
            end
          end else begin
            sec_ones_nx = sec_ones + 4'd1;
          end
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      if (press_lap) begin
        if (lap_active) begin
          lap_nx = 1'b0;
        end else if (state == RUN) begin
          snap_so_nx = sec_ones;
          snap_st_nx = sec_tens;
          snap_mo_nx = min_ones;
          snap_mt_nx = min_tens;
          lap_nx     = 1'b1;
        end
      end
    end
  end

  // State registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ss_prev    <= 1'b1;
      clr_prev   <= 1'b1;
      lap_prev   <= 1'b1;
      presc      <= '0;
      sec_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      min_ones   <= 4'd0;
      min_tens   <= 4'd0;
      snap_so    <= 4'd0;
      snap_st    <= 4'd0;
      snap_mo    <= 4'd0;
      snap_mt    <= 4'd0;
      lap_active <= 1'b0;
      first      <= 4'd0;
      second     <= 4'd0;
      third      <= 4'd0;
      fourth     <= 4'd0;
      running    <= 1'b0;
      rollover   <= 1'b0;
    end else begin
      state      <= state_nx;
      ss_prev    <= start_stop;
      clr_prev   <= clear;
      lap_prev   <= lap;
      presc      <= presc_nx;
      sec_ones   <= sec_ones_nx;
      sec_tens   <= sec_tens_nx;
      min_ones   <= min_ones_nx;
      min_tens   <= min_tens_nx;
      snap_so    <= snap_so_nx;
      snap_st    <= snap_st_nx;
      snap_mo    <= snap_mo_nx;
      snap_mt    <= snap_mt_nx;
      lap_active <= lap_nx;
      first      <= lap_nx ? snap_so_nx : sec_ones_nx;
      second     <= lap_nx ? snap_st_nx : sec_tens_nx;
      third      <= lap_nx ? snap_mo_nx : min_ones_nx;
      fourth     <= lap_nx ? snap_mt_nx : min_tens_nx;
      running    <= (state_nx == RUN);
      rollover   <= wrap;
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Self-checking bench for stopwatch_bcd_core. The reference model keeps
// elapsed time as an integer number of seconds and derives the digits
// with division and modulo.
module tb_stopwatch_bcd_core;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] first, second, third, fourth;
  logic       running, lap_active, rollover;

  int compared = 0;
  int mismatched = 0;

  // reference model state
  int m_secs = 0;
  int m_frac = 0;
  int m_mode = 0;  // 0 idle, 1 run, 2 pause
  bit m_lap = 0;
  int m_snap = 0;
  bit m_roll = 0;
  bit p_ss = 1, p_clr = 1, p_lap = 1;

  stopwatch_bcd_core #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
    .first(first), .second(second), .third(third), .fourth(fourth),
    .running(running), .lap_active(lap_active), .rollover(rollover)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit rn, input bit ss, input bit cl, input bit lp);
    bit pc, ps, pl;
    int old_mode, old_secs;
    if (!rn) begin
      m_secs = 0; m_frac = 0; m_mode = 0; m_lap = 0; m_snap = 0; m_roll = 0;
      p_ss = 1; p_clr = 1; p_lap = 1;
      return;
    end
    pc = cl && !p_clr;
    ps = ss && !p_ss && !pc;
    pl = lp && !p_lap && !pc && !ps;
    m_roll = 0;
    if (pc) begin
      m_mode = 0; m_frac = 0; m_secs = 0; m_lap = 0;
    end else begin
      old_mode = m_mode;
      old_secs = m_secs;
      if (old_mode == 1 && !ps) begin
        m_frac++;
        if (m_frac == TD) begin
          m_frac = 0;
          m_secs++;
          if (m_secs == 3600) begin
            m_secs = 0;
            m_roll = 1;
          end
        end
      end
      if (ps) m_mode = (old_mode == 1) ? 2 : 1;
      if (pl) begin
        if (m_lap) m_lap = 0;
        else if (old_mode == 1) begin
          m_snap = old_secs;
          m_lap = 1;
        end
      end
    end
    p_ss = ss; p_clr = cl; p_lap = lp;
  endtask

  function automatic logic [18:0] expv();
    int v;
    v = m_lap ? m_snap : m_secs;
    return {4'((v % 60) % 10), 4'((v % 60) / 10), 4'((v / 60) % 10), 4'(v / 600),
            (m_mode == 1), m_lap, m_roll};
  endfunction

  function automatic logic [18:0] gotv();
    return {first, second, third, fourth, running, lap_active, rollover};
  endfunction

  task automatic cycle(input bit rn, input bit ss, input bit cl, input bit lp);
    rst_n = rn; start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model_step(rn, ss, cl, lp);
    #1;
  endtask

  task automatic do_clear();
    cycle(1, 0, 1, 0);
    cycle(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    compared++;
    if (gotv() !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h want %h", gotv(), 19'd0);
    end
    cycle(1, 0, 0, 0);
    compared++;
    if (gotv() !== expv()) begin
      mismatched++;
      $display("FAIL reset_idle: got %h want %h", gotv(), expv());
    end
  endtask

  task automatic test_start_count();
    cycle(1, 1, 0, 0);
    compared++;
    if (running !== 1'b1) begin
      mismatched++;
      $display("FAIL start_running: got %b want 1", running);
    end
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0, 0);
      compared++;
      if (gotv() !== expv()) begin
        mismatched++;
        $display("FAIL count_cyc%0d: got %h want %h", i, gotv(), expv());
      end
      if (i == 3) begin
        compared++;
        if (first !== 4'd1) begin
          mismatched++;
          $display("FAIL first_tick: got %0d want 1", first);
        end
      end
    end
    compared++;
    if ({second, first} !== {4'd1, 4'd0}) begin
      mismatched++;
      $display("FAIL ten_seconds: got %0d%0d want 10", second, first);
    end
  endtask

  task automatic test_pause();
    do_clear();
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    compared++;
    if (running !== 1'b0) begin
      mismatched++;
      $display("FAIL pause_running: got %b want 0", running);
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 0, 0);
      compared++;
      if (gotv() !== expv() || first !== 4'd0) begin
        mismatched++;
        $display("FAIL pause_hold%0d: got %h want %h", i, gotv(), expv());
      end
    end
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    compared++;
    if (first !== 4'd0) begin
      mismatched++;
      $display("FAIL resume_early: got %0d want 0", first);
    end
    cycle(1, 0, 0, 0);
    compared++;
    if (first !== 4'd1 || gotv() !== expv()) begin
      mismatched++;
      $display("FAIL resume_tick: got %h want %h", gotv(), expv());
    end
  endtask

  task automatic test_lap();
    do_clear();
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 28; i++) cycle(1, 0, 0, 0);
    compared++;
    if (first !== 4'd7) begin
      mismatched++;
      $display("FAIL lap_preload: got %0d want 7", first);
    end
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 0, 0);
      compared++;
      if (gotv() !== expv()) begin
        mismatched++;
        $display("FAIL lap_frozen%0d: got %h want %h", i, gotv(), expv());
      end
    end
    compared++;
    if ({fourth, third, second, first, lap_active} !== {16'h0007, 1'b1}) begin
      mismatched++;
      $display("FAIL lap_hold: got %h%b want 0007 1", {fourth, third, second, first}, lap_active);
    end
    cycle(1, 0, 0, 1);
    compared++;
    if ({fourth, third, second, first, lap_active} !== {16'h0012, 1'b0}) begin
      mismatched++;
      $display("FAIL lap_release: got %h%b want 0012 0", {fourth, third, second, first}, lap_active);
    end
    cycle(1, 0, 0, 0);
  endtask

  task automatic test_clear_coincide();
    do_clear();
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 42 * TD; i++) begin
      cycle(1, 0, 0, (i == 100));
      if (i == 100) cycle(1, 0, 0, 0);
    end
    compared++;
    if ({second, first} !== {4'd4, 4'd2} && lap_active === 1'b0) begin
      mismatched++;
      $display("FAIL clr_preload: got %0d%0d want 42", second, first);
    end
    cycle(1, 1, 1, 0);
    compared++;
    if (gotv() !== 19'd0 || gotv() !== expv()) begin
      mismatched++;
      $display("FAIL clr_coincide: got %h want %h", gotv(), 19'd0);
    end
    cycle(1, 0, 0, 0);
    compared++;
    if (gotv() !== 19'd0) begin
      mismatched++;
      $display("FAIL clr_stays_idle: got %h want %h", gotv(), 19'd0);
    end
  endtask

  task automatic test_held_reset();
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 0);
      compared++;
      if (running !== 1'b0 || gotv() !== expv()) begin
        mismatched++;
        $display("FAIL held_ss%0d: got %h want %h", i, gotv(), expv());
      end
    end
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    compared++;
    if (running !== 1'b1) begin
      mismatched++;
      $display("FAIL held_repress: got %b want 1", running);
    end
    cycle(1, 0, 0, 0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 9; i++) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    compared++;
    if (gotv() !== 19'd0) begin
      mismatched++;
      $display("FAIL mid_reset: got %h want %h", gotv(), 19'd0);
    end
    cycle(1, 0, 0, 0);
  endtask

  task automatic test_rollover();
    int rc;
    do_clear();
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 3599 * TD; i++) begin
      cycle(1, 0, 0, 0);
      compared++;
      if (gotv() !== expv()) begin
        mismatched++;
        $display("FAIL preload_cyc%0d: got %h want %h", i, gotv(), expv());
      end
    end
    compared++;
    if ({fourth, third, second, first} !== 16'h5959) begin
      mismatched++;
      $display("FAIL at_5959: got %h want 5959", {fourth, third, second, first});
    end
    rc = 0;
    for (int i = 0; i < 2 * TD; i++) begin
      cycle(1, 0, 0, 0);
      if (rollover === 1'b1) begin
        rc++;
        compared++;
        if ({fourth, third, second, first} !== 16'h0000) begin
          mismatched++;
          $display("FAIL wrap_digits: got %h want 0000", {fourth, third, second, first});
        end
      end
      compared++;
      if (gotv() !== expv()) begin
        mismatched++;
        $display("FAIL wrap_cyc%0d: got %h want %h", i, gotv(), expv());
      end
    end
    compared++;
    if (rc != 1) begin
      mismatched++;
      $display("FAIL rollover_width: got %0d want 1", rc);
    end
  endtask

  task automatic test_random();
    bit ss, cl, lp, rn;
    ss = 0; cl = 0; lp = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) ss = ~ss;
      if ($urandom_range(0, 63) == 0) cl = ~cl;
      if ($urandom_range(0, 9) == 0) lp = ~lp;
      rn = ($urandom_range(0, 999) != 0);
      cycle(rn, ss, cl, lp);
      compared++;
      if (gotv() !== expv()) begin
        mismatched++;
        $display("FAIL random_cyc%0d: got %h want %h", i, gotv(), expv());
      end
      compared++;
      if (first > 4'd9 || second > 4'd5 || third > 4'd9 || fourth > 4'd5) begin
        mismatched++;
        $display("FAIL bcd_range%0d: got %h want in range", i, {fourth, third, second, first});
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_pause();
    test_lap();
    test_clear_coincide();
    test_held_reset();
    test_mid_reset();
    test_rollover();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd_core.md
Name: stopwatch_bcd_core

Overview:
- MM:SS stopwatch counter for the seven-segment stopwatch display path.
- Converts debounced button levels into start/stop, clear and lap control.
- Prescales the system clock to a 1 Hz tick and keeps four BCD digits.
- Feeds the four digit inputs of the display digit multiplexer: first = seconds ones, second = seconds tens, third = minutes ones, fourth = minutes tens.

Parameters:
- TICK_DIV, 100000000: clock cycles per stopwatch second; legal values are 2 and above; benches use 4.
- CNT_W, 27: prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start_stop  input  1  debounced button level; each rising edge toggles run/pause.
- clear  input  1  debounced button level; each rising edge zeroes the stopwatch.
- lap  input  1  debounced button level; each rising edge toggles the lap freeze.
- first  output  4  displayed seconds-ones BCD digit, 0-9.
- second  output  4  displayed seconds-tens BCD digit, 0-5.
- third  output  4  displayed minutes-ones BCD digit, 0-9.
- fourth  output  4  displayed minutes-tens BCD digit, 0-5.
- running  output  1  high while in state RUN.
- lap_active  output  1  high while the display is frozen.
- rollover  output  1  one-cycle pulse when the count wraps from 59:59 to 00:00.

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - state to IDLE;
  - prescaler and all live digits to 0;
  - lap latch and all outputs to 0;
  - the button history registers to 1, so a button already held at reset release is not seen as a press.
- Edge detection: press_x = x & ~x_prev, where x_prev is registered every cycle. One press is detected per rising edge of the input.
- State machine:
  - IDLE: start_stop press -> RUN.
  - RUN: start_stop press -> PAUSE.
  - PAUSE: start_stop press -> RUN.
  - clear press in any state -> IDLE.
- Priority: when presses coincide, clear > start_stop > lap. A clear press in the same cycle as another press discards the other press.
- Clear press: zeroes the prescaler and live digits, drops lap_active and cancels any pending tick in that cycle.
- Prescaler:
  - Counts only in RUN and holds its value in PAUSE, so the fractional second is kept across a pause.
  - When it equals TICK_DIV-1 in RUN, it returns to 0 and asserts an internal tick for that cycle.
- Tick: increments the live digits as a BCD cascade:
  - seconds ones wrap 9->0 and carry into seconds tens;
  - seconds tens wrap 5->0 and carry into minutes ones;
  - minutes ones wrap 9->0 and carry into minutes tens;
  - minutes tens wrap 5->0.
  - The 59:59 -> 00:00 wrap asserts rollover for exactly that cycle. The counter keeps running after the wrap.
- Latency:
  - The first tick after entering RUN occurs TICK_DIV cycles later.
  - Outputs change on the clock edge after the tick cycle; registered digits are visible one cycle after the tick.
  - The digit outputs are registered and are never combinational from the buttons.
- Lap:
  - A lap press in RUN with lap_active=0 copies the live digits into a snapshot and sets lap_active=1.
  - A lap press while lap_active=1, in RUN or PAUSE, clears lap_active.
  - A lap press in IDLE, or in PAUSE with lap_active=0, is ignored.
- Output select: first..fourth show the snapshot while lap_active=1 and the live digits otherwise. Live counting continues during lap.
- Invariant: no digit ever leaves its BCD range.

Test Plan:
- Reset, then start_stop press, TICK_DIV=4 -> running=1 next cycle; first=1 after 4 cycles; first=9 then second=1, first=0 after 40 cycles.
- Preload by running 3599 ticks to 59:59, then one more tick -> digits 0/0/0/0 and rollover high for exactly 1 cycle.
- Run 2 cycles into a second, press start_stop to pause, hold 20 cycles, press start_stop again -> next tick 2 cycles after resume; digits static during the pause.
- At 00:07 press lap, run 5 more ticks -> outputs hold 7/0/0/0 with lap_active=1; press lap again -> outputs show 2/1/0/0.
- Press clear and start_stop in the same cycle while RUN at 00:42 -> state IDLE, digits 0, running=0, lap_active=0, rollover=0.
- Hold start_stop high through reset release -> no transition; state stays IDLE until the button is released and pressed again.
- Pulse rst_n low for 1 cycle mid-count -> all outputs 0 on the next edge.
